// File: rtl/div_16_pkg.sv
// Shared constants, state encoding and helpers for the Q2.14 restoring divider.
// Imported by the interface, the step sub-module and the div_16 top.
package div_16_pkg;

    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 14;
    localparam int DIV_ITER = DATA_W + FRAC_W;
    localparam int MAG_W    = DATA_W + 1;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] quot;
        logic              ovf;
    } sat_res_t;

    // One extra bit so that |-32768| = 32768 is representable as an unsigned magnitude.
    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
        logic signed [MAG_W-1:0] ext;
        ext = {v[DATA_W-1], v};
        return ext[MAG_W-1] ? MAG_W'(-ext) : MAG_W'(ext);
    endfunction

endpackage

// File: rtl/div_16_if.sv
// Start/done handshake and operand/result bundle between a requester and div_16.
interface div_16_if;
    import div_16_pkg::*;

    logic              start;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quot_out;
    logic              ovf;
    logic              div_zero;

    modport master (
        output start, data_a, data_b,
        input  busy, done, quot_out, ovf, div_zero
    );

    modport slave (
        input  start, data_a, data_b,
        output busy, done, quot_out, ovf, div_zero
    );

endinterface

// File: rtl/div_16_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module div_16_step
    import div_16_pkg::*;
(
    input  logic [MAG_W-1:0] rem_in,
    input  logic             msb_in,
    input  logic [MAG_W-1:0] divisor,
    output logic [MAG_W-1:0] rem_out,
    output logic             qbit
);

    logic [MAG_W:0]   rem_sh;
    logic [MAG_W-1:0] diff;

    // rem_out < divisor always, so the truncated difference is exact when qbit=1.
    always_comb begin
        rem_sh  = {rem_in, msb_in};
        qbit    = (rem_sh >= {1'b0, divisor});
        diff    = rem_sh[MAG_W-1:0] - divisor;
        rem_out = qbit ? diff : rem_sh[MAG_W-1:0];
    end

endmodule

// File: rtl/div_16.sv
// Sequential signed Q2.14 divider: quot = trunc((a << 14) / b), one quotient bit per
// clock, saturated to Q2.14, fixed 32-cycle start-to-done latency.
module div_16
    import div_16_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    div_16_if.slave  bus
);

    div_state_t state_q, state_d;
    logic       accept;
    logic       busy;
    logic       last_iter;

    logic signed [DATA_W-1:0] a_s, b_s;
    logic [MAG_W-1:0]         a_mag, b_mag;

    logic [CNT_W-1:0]    iter_p0;
    logic                sign_q_p0;
    logic                sign_a_p0;
    logic [MAG_W-1:0]    divisor_p0;
    logic [MAG_W-1:0]    rem_p0;
    logic [DIV_ITER-1:0] dividend_p0;
    logic [DIV_ITER-1:0] quot_p0;

    logic [MAG_W-1:0] rem_nxt;
    logic             qbit;
    logic             div_zero_p0;
    sat_res_t         sat_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] quot_out_p1;
    logic              ovf_p1;
    logic              div_zero_p1;

    function automatic sat_res_t saturate(
        input logic [DIV_ITER-1:0] mag,
        input logic                neg,
        input logic                dz,
        input logic                sign_a
    );
        sat_res_t r;
        r.ovf  = 1'b0;
        r.quot = '0;
        if (dz) begin
            r.quot = sign_a ? Q_MIN : Q_MAX;
        end else if (!neg) begin
            if (mag > DIV_ITER'(Q_MAX)) begin
                r.quot = Q_MAX;
                r.ovf  = 1'b1;
            end else begin
                r.quot = mag[DATA_W-1:0];
            end
        end else begin
            // Negative side reaches one further: magnitude 32768 maps exactly to 0x8000.
            if (mag > DIV_ITER'(Q_MIN)) begin
                r.quot = Q_MIN;
                r.ovf  = 1'b1;
            end else begin
                r.quot = DATA_W'(~mag[DATA_W-1:0] + 1'b1);
            end
        end
        return r;
    endfunction

    assign a_s       = $signed(bus.data_a);
    assign b_s       = $signed(bus.data_b);
    assign a_mag     = abs_mag(a_s);
    assign b_mag     = abs_mag(b_s);
    assign last_iter = (iter_p0 == CNT_W'(DIV_ITER - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DIV_CALC;
                end
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                busy    = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DIV_CALC;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            iter_p0 <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                iter_p0 <= '0;
            end else if (state_q == DIV_CALC) begin
                iter_p0 <= iter_p0 + 1'b1;
            end
        end
    end

    // Stage p0: operand capture and the iterative remainder/quotient datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q_p0   <= a_s[DATA_W-1] ^ b_s[DATA_W-1];
            sign_a_p0   <= a_s[DATA_W-1];
            divisor_p0  <= b_mag;
            dividend_p0 <= DIV_ITER'({a_mag, {FRAC_W{1'b0}}});
            rem_p0      <= '0;
            quot_p0     <= '0;
        end else if (state_q == DIV_CALC) begin
            rem_p0      <= rem_nxt;
            dividend_p0 <= dividend_p0 << 1;
            quot_p0     <= {quot_p0[DIV_ITER-2:0], qbit};
        end
    end

    div_16_step u_step (
        .rem_in  (rem_p0),
        .msb_in  (dividend_p0[DIV_ITER-1]),
        .divisor (divisor_p0),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    assign div_zero_p0 = (divisor_p0 == '0);
    assign sat_p0      = saturate(quot_p0, sign_q_p0, div_zero_p0, sign_a_p0);

    // Stage p1: result registers, loaded once in FIX and held until the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            quot_out_p1 <= '0;
            ovf_p1      <= 1'b0;
            div_zero_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state_q == DIV_FIX);
            if (state_q == DIV_FIX) begin
                quot_out_p1 <= sat_p0.quot;
                ovf_p1      <= sat_p0.ovf;
                div_zero_p1 <= div_zero_p0;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = vld_p1;
    assign bus.quot_out = quot_out_p1;
    assign bus.ovf      = ovf_p1;
    assign bus.div_zero = div_zero_p1;

endmodule

// File: tb/tb_div_16.sv
// Scoreboard bench for div_16: directed corner table, handshake/reset scenarios and
// randomized operands checked against an integer-arithmetic reference model.
module tb_div_16;
    import div_16_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        ovf;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rst_q;
    always #5 clk = ~clk;

    div_16_if dif ();

    div_16 u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] hold_q;
    logic        hold_ovf;
    logic        hold_dz;
    logic [15:0] ra, rb;

    logic [15:0] corners [5] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000};

    // {a, b, expected quot, ovf, div_zero}
    logic [49:0] dir [17] = '{
        {16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0},
        {16'h0001, 16'h0003, 16'h1555, 1'b0, 1'b0},
        {16'hFFFF, 16'h0003, 16'hEAAB, 1'b0, 1'b0},
        {16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0},
        {16'hE000, 16'h4000, 16'hE000, 1'b0, 1'b0},
        {16'h0001, 16'hFFFD, 16'hEAAB, 1'b0, 1'b0},
        {16'h4000, 16'h2000, 16'h7FFF, 1'b1, 1'b0},
        {16'hC000, 16'h2000, 16'h8000, 1'b0, 1'b0},
        {16'hC000, 16'h1000, 16'h8000, 1'b1, 1'b0},
        {16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0},
        {16'h1234, 16'h0000, 16'h7FFF, 1'b0, 1'b1},
        {16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1},
        {16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1},
        {16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0},
        {16'h8000, 16'h8000, 16'h4000, 1'b0, 1'b0},
        {16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0},
        {16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint num, q;
        e.a   = a;
        e.b   = b;
        e.dz  = (b == 16'h0000);
        e.ovf = 1'b0;
        e.cyc = 0;
        if (e.dz) begin
            e.q = a[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            num = longint'($signed(a)) * 16384;
            q   = num / longint'($signed(b));
            if (q > 32767) begin
                e.q   = 16'h7FFF;
                e.ovf = 1'b1;
            end else if (q < -32768) begin
                e.q   = 16'h8000;
                e.ovf = 1'b1;
            end else begin
                e.q = q[15:0];
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(7))
            0, 1:    return corners[$urandom_range(4)];
            2:       return 16'($urandom_range(255));
            default: return 16'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Monitor: pops one expectation per done, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_q === 1'b1) begin
            hold_q   = 16'h0000;
            hold_ovf = 1'b0;
            hold_dz  = 1'b0;
        end
        if (dif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("quot", {16'h0, dif.quot_out}, {16'h0, mon_e.q});
                check("ovf", {31'h0, dif.ovf}, {31'h0, mon_e.ovf});
                check("div_zero", {31'h0, dif.div_zero}, {31'h0, mon_e.dz});
                check("latency", cyc, mon_e.cyc);
                hold_q   = mon_e.q;
                hold_ovf = mon_e.ovf;
                hold_dz  = mon_e.dz;
            end
        end else begin
            check("hold", {14'h0, dif.quot_out, dif.ovf, dif.div_zero},
                          {14'h0, hold_q, hold_ovf, hold_dz});
        end
    end

    task automatic launch(input exp_t e, input bit push);
        exp_t x;
        x            = e;
        dif.start    = 1'b1;
        dif.data_a   = e.a;
        dif.data_b   = e.b;
        x.cyc        = cyc + 32;
        if (push) sb_q.push_back(x);
        @(negedge clk);
        dif.start  = 1'b0;
        dif.data_a = 16'($urandom);
        dif.data_b = 16'($urandom);
        check("busy_after_start", {31'h0, dif.busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dif.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (dif.done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        exp_t e;
        dif.start  = 1'b0;
        dif.data_a = 16'h0000;
        dif.data_b = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'h0, dif.busy}, 32'd0);
        check("rst_done", {31'h0, dif.done}, 32'd0);
        check("rst_quot", {16'h0, dif.quot_out}, 32'd0);
        check("rst_ovf", {31'h0, dif.ovf}, 32'd0);
        check("rst_div_zero", {31'h0, dif.div_zero}, 32'd0);

        // Directed table; after the first op each launch lands in the DONE cycle.
        for (int i = 0; i < 17; i++) begin
            {e.a, e.b, e.q, e.ovf, e.dz} = dir[i];
            e.cyc = 0;
            launch(e, 1'b1);
            wait_done();
        end
        repeat (20) @(negedge clk);

        // start pulsed mid-CALC must be ignored.
        e = model(16'h2000, 16'h4000);
        launch(e, 1'b1);
        repeat (5) @(negedge clk);
        dif.start  = 1'b1;
        dif.data_a = 16'h4000;
        dif.data_b = 16'h2000;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // Reset during CALC cycle 10 abandons the op.
        e = model(16'h7000, 16'h3000);
        launch(e, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'h0, dif.busy}, 32'd0);
        check("midrst_done", {31'h0, dif.done}, 32'd0);
        check("midrst_quot", {16'h0, dif.quot_out}, 32'd0);
        check("midrst_flags", {30'h0, dif.ovf, dif.div_zero}, 32'd0);
        repeat (40) @(negedge clk);
        e = model(16'h0001, 16'hFFFD);
        launch(e, 1'b1);
        wait_done();

        for (int i = 0; i < 2000; i++) begin
            ra = pick();
            rb = pick();
            if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
            launch(model(ra, rb), 1'b1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
